reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have one parameter: CLR_VALUE, default 8'h00, the data written to every register during a clear sweep.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port REQ_A, input, 1 bit: write request from requester A (ALU writeback).
REQ-005 The block SHALL have port ADDR_A, input, 3 bits: destination register for A.
REQ-006 The block SHALL have port DATA_A, input, 8 bits: write data for A.
REQ-007 The block SHALL have port GNT_A, output, 1 bit: one-cycle grant pulse to A.
REQ-008 The block SHALL have ports REQ_B, ADDR_B, DATA_B and GNT_B, identical to the A ports, for requester B (load unit).
REQ-009 The block SHALL have port CLR_START, input, 1 bit: request to start a clear sweep.
REQ-010 The block SHALL have port WRITE, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port INADDRESS, output, 3 bits: register-file write address.
REQ-012 The block SHALL have port IN, output, 8 bits: register-file write data.
REQ-013 The block SHALL have port BUSY, output, 1 bit: high while a clear sweep is in progress.
REQ-014 The block SHALL have port CLR_DONE, output, 1 bit: one-cycle pulse when a clear sweep completes.

Function
REQ-015 All outputs SHALL be registered; the register file samples WRITE/INADDRESS/IN on the rising edge after they are driven.
REQ-016 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-017 In IDLE with CLR_START low, at each edge the block SHALL pick at most one requester and update WRITE, INADDRESS, IN and GNT_x together.
- Winner x: WRITE=1, INADDRESS=ADDR_x, IN=DATA_x, GNT_x=1, other GNT=0.
- No request: WRITE=0, both GNT=0, INADDRESS/IN hold their previous values.
REQ-018 Arbitration SHALL be round-robin using a 1-bit priority pointer PTR (0=A first, 1=B first).
- Single request: that requester wins regardless of PTR.
- Both request: the PTR side wins.
- After any grant, PTR SHALL point to the non-granted side.
REQ-019 A requester SHALL drop REQ in the cycle GNT is high; REQ still high at the next edge SHALL be treated as a new request, allowing one write per cycle.
REQ-020 Simultaneous requests to the same address SHALL produce two writes in consecutive cycles, in round-robin order; no merging.
REQ-021 CLR_START high at an edge in IDLE SHALL move the FSM to CLEAR and take priority over any simultaneous request.
- No GNT SHALL be issued at that edge.
- The first clear write is issued at that edge: INADDRESS=0, IN=CLR_VALUE, WRITE=1, BUSY=1.
REQ-022 In CLEAR, a 3-bit counter SHALL increment each edge, driving INADDRESS=1..7 with WRITE=1 and IN=CLR_VALUE; the sweep is 8 consecutive write cycles.
REQ-023 At the edge after the INADDRESS=7 write, the block SHALL:
- return to IDLE;
- set WRITE=0, BUSY=0, CLR_DONE=1 for one cycle;
- wrap the counter to 0;
- leave PTR unchanged;
- issue no grant at that edge.
REQ-024 In CLEAR, requests SHALL be stalled (GNT low), CLR_START SHALL be ignored, and pending requests SHALL be arbitrated normally from the first IDLE edge.
REQ-025 CLR_START held high continuously SHALL start a new sweep at the first IDLE edge after CLR_DONE.

Reset
REQ-026 RESET low SHALL immediately and asynchronously force:
- FSM=IDLE, PTR=0, counter=0;
- WRITE=0, INADDRESS=0, IN=0;
- GNT_A=GNT_B=0, BUSY=0, CLR_DONE=0.
REQ-027 RESET asserted mid-sweep SHALL abort the sweep with no CLR_DONE; registers already cleared are not restored.
REQ-028 After RESET deasserts, the first rising edge SHALL behave as IDLE with PTR=0.

Verification
REQ-029 The bench SHALL cover single request: REQ_A=1, ADDR_A=3, DATA_A=8'h5A for one edge -> that edge gives WRITE=1, INADDRESS=3, IN=8'h5A, GNT_A=1; the next edge gives WRITE=0.
REQ-030 The bench SHALL cover contention: both REQ held high for 4 edges from reset -> grants in order A,B,A,B, and WRITE high on all 4 cycles.
REQ-031 The bench SHALL cover a same-address conflict: A writes 8'h11 and B writes 8'h22, both to reg 5, with PTR=1 -> the B write then the A write; reg 5 ends at 8'h11.
REQ-032 The bench SHALL cover clear vs request: CLR_START and REQ_A high at the same edge -> INADDRESS sequence 0..7 with IN=CLR_VALUE over 8 cycles, BUSY high for 8 cycles, CLR_DONE on the 9th cycle, GNT_A on the 10th edge.
REQ-033 The bench SHALL cover reset mid-sweep: RESET low after INADDRESS=4 -> all outputs 0 immediately, and no CLR_DONE.
REQ-034 The bench SHALL cover a clear with CLR_VALUE=8'hFF -> all 8 registers read back 8'hFF.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: round-robin between two writers (A, B), plus an
// eight-cycle clear sweep that writes CLR_VALUE into every register.
`timescale 1ns/1ps

module reg_write_arbiter #(
  parameter logic [7:0] CLR_VALUE = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic [2:0] ADDR_A,
  input  logic [7:0] DATA_A,
  output logic       GNT_A,
  input  logic       REQ_B,
  input  logic [2:0] ADDR_B,
  input  logic [7:0] DATA_B,
  output logic       GNT_B,
  input  logic       CLR_START,
  output logic       WRITE,
  output logic [2:0] INADDRESS,
  output logic [7:0] IN,
  output logic       BUSY,
  output logic       CLR_DONE
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic [2:0] inaddr_q, inaddr_d;
  logic [7:0] in_q, in_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       busy_q, busy_d;
  logic       clr_done_q, clr_done_d;

  logic       win_a;
  logic       win_b;

  // A lone requester always wins; on contention the pointer picks the side.
  assign win_a = REQ_A && (!REQ_B || (ptr_q == PTR_A));
  assign win_b = REQ_B && (!REQ_A || (ptr_q == PTR_B));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    write_d    = 1'b0;
    inaddr_d   = inaddr_q;
    in_d       = in_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    busy_d     = 1'b0;
    clr_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (CLR_START) begin
          // The sweep's first write (register 0) goes out on the starting edge.
          state_d  = CLEAR;
          cnt_d    = 3'd0;
          write_d  = 1'b1;
          inaddr_d = 3'd0;
          in_d     = CLR_VALUE;
          busy_d   = 1'b1;
        end else if (win_a) begin
          write_d  = 1'b1;
          inaddr_d = ADDR_A;
          in_d     = DATA_A;
          gnt_a_d  = 1'b1;
          ptr_d    = PTR_B;
        end else if (win_b) begin
          write_d  = 1'b1;
          inaddr_d = ADDR_B;
          in_d     = DATA_B;
          gnt_b_d  = 1'b1;
          ptr_d    = PTR_A;
        end
      end

      CLEAR: begin
        if (cnt_q == 3'd7) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          write_d  = 1'b1;
          inaddr_d = cnt_q + 3'd1;
          in_d     = CLR_VALUE;
          busy_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_A;
      cnt_q      <= 3'd0;
      write_q    <= 1'b0;
      inaddr_q   <= 3'd0;
      in_q       <= 8'h00;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      inaddr_q   <= inaddr_d;
      in_q       <= in_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign WRITE     = write_q;
  assign INADDRESS = inaddr_q;
  assign IN        = in_q;
  assign GNT_A     = gnt_a_q;
  assign GNT_B     = gnt_b_q;
  assign BUSY      = busy_q;
  assign CLR_DONE  = clr_done_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: two instances (CLR_VALUE 8'hFF and
// default 8'h00) share stimulus; each feeds a small register file.
`timescale 1ns/1ps

module tb_reg_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, clr_start;
  logic [2:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;

  logic       w_ff, gnt_a_ff, gnt_b_ff, busy_ff, done_ff;
  logic [2:0] a_ff;
  logic [7:0] i_ff;
  logic       w_00, gnt_a_00, gnt_b_00, busy_00, done_00;
  logic [2:0] a_00;
  logic [7:0] i_00;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(.CLR_VALUE(8'hFF)) u_dut_ff (
    .CLK(clk), .RESET(rst_n),
    .REQ_A(req_a), .ADDR_A(addr_a), .DATA_A(data_a), .GNT_A(gnt_a_ff),
    .REQ_B(req_b), .ADDR_B(addr_b), .DATA_B(data_b), .GNT_B(gnt_b_ff),
    .CLR_START(clr_start), .WRITE(w_ff), .INADDRESS(a_ff), .IN(i_ff),
    .BUSY(busy_ff), .CLR_DONE(done_ff)
  );

  reg_write_arbiter u_dut_00 (
    .CLK(clk), .RESET(rst_n),
    .REQ_A(req_a), .ADDR_A(addr_a), .DATA_A(data_a), .GNT_A(gnt_a_00),
    .REQ_B(req_b), .ADDR_B(addr_b), .DATA_B(data_b), .GNT_B(gnt_b_00),
    .CLR_START(clr_start), .WRITE(w_00), .INADDRESS(a_00), .IN(i_00),
    .BUSY(busy_00), .CLR_DONE(done_00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register files written by the DUT outputs, as the real file would be.
  logic [7:0] env_rf_ff [8];
  logic [7:0] env_rf_00 [8];
  always @(posedge clk) begin
    if (w_ff) env_rf_ff[a_ff] <= i_ff;
    if (w_00) env_rf_00[a_00] <= i_00;
  end

  typedef struct {
    bit       write;
    bit [2:0] addr;
    bit [7:0] in_ff;
    bit [7:0] in_00;
    bit       gnt_a;
    bit       gnt_b;
    bit       busy;
    bit       done;
    bit       addr_known;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: requester priority, a queue of pending clear steps, and
  // the register contents that should result.
  bit       m_prio_b;
  int       m_plan[$];
  exp_t     m_out;
  bit       m_pend;
  bit [7:0] m_rf_ff [8];
  bit [7:0] m_rf_00 [8];
  bit       m_written [8];

  function automatic void model_reset();
    m_prio_b = 1'b0;
    m_plan.delete();
    m_out = '{default: 0};
    m_out.addr_known = 1'b1;
    m_pend = 1'b0;
  endfunction

  function automatic void model_step(bit ra, bit [2:0] aa, bit [7:0] da,
                                     bit rb, bit [2:0] ab, bit [7:0] db, bit clr);
    if (m_pend) begin
      m_rf_ff[m_out.addr]   = m_out.in_ff;
      m_rf_00[m_out.addr]   = m_out.in_00;
      m_written[m_out.addr] = 1'b1;
    end
    m_out.write = 0; m_out.gnt_a = 0; m_out.gnt_b = 0;
    m_out.busy  = 0; m_out.done  = 0;
    if (m_plan.size() > 0) begin
      int item;
      item = m_plan.pop_front();
      if (item < 8) begin
        m_out.write = 1; m_out.addr = item[2:0];
        m_out.in_ff = 8'hFF; m_out.in_00 = 8'h00;
        m_out.busy = 1; m_out.addr_known = 1;
      end else begin
        m_out.done = 1;
        m_out.addr_known = 0;
      end
    end else if (clr) begin
      for (int i = 1; i <= 8; i++) m_plan.push_back(i);
      m_out.write = 1; m_out.addr = 3'd0;
      m_out.in_ff = 8'hFF; m_out.in_00 = 8'h00;
      m_out.busy = 1; m_out.addr_known = 1;
    end else if (ra && (!rb || !m_prio_b)) begin
      m_out.write = 1; m_out.addr = aa; m_out.in_ff = da; m_out.in_00 = da;
      m_out.gnt_a = 1; m_out.addr_known = 1; m_prio_b = 1'b1;
    end else if (rb) begin
      m_out.write = 1; m_out.addr = ab; m_out.in_ff = db; m_out.in_00 = db;
      m_out.gnt_b = 1; m_out.addr_known = 1; m_prio_b = 1'b0;
    end
    m_pend = m_out.write;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check("write_ff", 32'(w_ff), 32'(e.write));
    check("write_00", 32'(w_00), 32'(e.write));
    if (e.addr_known) begin
      check("inaddress_ff", 32'(a_ff), 32'(e.addr));
      check("inaddress_00", 32'(a_00), 32'(e.addr));
      check("in_ff", 32'(i_ff), 32'(e.in_ff));
      check("in_00", 32'(i_00), 32'(e.in_00));
    end
    check("gnt_a_ff", 32'(gnt_a_ff), 32'(e.gnt_a));
    check("gnt_a_00", 32'(gnt_a_00), 32'(e.gnt_a));
    check("gnt_b_ff", 32'(gnt_b_ff), 32'(e.gnt_b));
    check("gnt_b_00", 32'(gnt_b_00), 32'(e.gnt_b));
    check("busy_ff", 32'(busy_ff), 32'(e.busy));
    check("busy_00", 32'(busy_00), 32'(e.busy));
    check("clr_done_ff", 32'(done_ff), 32'(e.done));
    check("clr_done_00", 32'(done_00), 32'(e.done));
  endtask

  // Monitor: outputs settle #1 after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_out(e);
      end
    end
  end

  task automatic drive(input bit ra, input bit [2:0] aa, input bit [7:0] da,
                       input bit rb, input bit [2:0] ab, input bit [7:0] db,
                       input bit clr);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    clr_start = clr;
    model_step(ra, aa, da, rb, ab, db, clr);
    exp_q.push_back(m_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
  endtask

  // Reset is applied mid-cycle; outputs must clear without waiting for an edge.
  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 0; req_b = 0; clr_start = 0;
    model_reset();
    #1;
    compare_out(m_out);
    exp_q.push_back(m_out);
  endtask

  task automatic check_regfile(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (m_written[i]) begin
        check({tag, "_rf_ff"}, 32'(env_rf_ff[i]), 32'(m_rf_ff[i]));
        check({tag, "_rf_00"}, 32'(env_rf_00[i]), 32'(m_rf_00[i]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int budget;
    rst_n = 1'b0;
    req_a = 0; req_b = 0; clr_start = 0;
    addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    for (int i = 0; i < 8; i++) begin
      m_rf_ff[i] = 0; m_rf_00[i] = 0; m_written[i] = 0;
    end
    model_reset();

    reset_cycle();
    reset_cycle();

    // Single request from A, then nothing.
    drive(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0);
    idle(2);

    // Same-address conflict with B holding priority; B drops after its grant.
    drive(1, 3'd5, 8'h11, 1, 3'd5, 8'h22, 0);
    drive(1, 3'd5, 8'h11, 0, 3'd5, 8'h22, 0);
    idle(2);
    check("same_addr_reg5", 32'(env_rf_ff[5]), 32'h11);
    check_regfile("same_addr");

    // Contention from reset: grants alternate A, B, A, B.
    reset_cycle();
    for (int i = 0; i < 4; i++) drive(1, 3'd1, 8'h30 + 8'(i), 1, 3'd2, 8'h40 + 8'(i), 0);
    idle(2);

    // Clear and A request together; A keeps requesting until granted.
    drive(1, 3'd6, 8'hC3, 0, 3'd0, 8'h00, 1);
    for (int i = 0; i < 9; i++) drive(1, 3'd6, 8'hC3, 0, 3'd0, 8'h00, 0);
    idle(2);
    check_regfile("clear_req");

    // CLR_START held high: back-to-back sweeps.
    for (int i = 0; i < 20; i++) drive(0, 3'd0, 8'h00, 1, 3'd4, 8'h77, 1);
    idle(3);

    // Reset after the INADDRESS=4 write of a sweep: no CLR_DONE may follow.
    for (int i = 0; i < 8; i++) drive(1, 3'(i), 8'h90 + 8'(i), 0, 3'd0, 8'h00, 0);
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1);
    idle(4);
    reset_cycle();
    reset_cycle();
    idle(10);
    check_regfile("reset_sweep");
    drive(1, 3'd2, 8'hA1, 1, 3'd3, 8'hB2, 0);
    idle(1);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) reset_cycle();
      else drive(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                 $urandom_range(0, 19) == 0);
    end
    idle(12);
    check_regfile("random");

    // A final clean sweep must leave every register at CLR_VALUE.
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 1);
    idle(10);
    for (int i = 0; i < 8; i++) begin
      check("sweep_ff", 32'(env_rf_ff[i]), 32'hFF);
      check("sweep_00", 32'(env_rf_00[i]), 32'h00);
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
